// File: rtl/ucode_pkg.sv
// Shared opcode, control-bit and state definitions for the microsequencer.
package ucode_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam int CB_HLT = 15;
  localparam int CB_MI  = 14;
  localparam int CB_RI  = 13;
  localparam int CB_RO  = 12;
  localparam int CB_IO  = 11;
  localparam int CB_II  = 10;
  localparam int CB_AI  = 9;
  localparam int CB_AO  = 8;
  localparam int CB_EO  = 7;
  localparam int CB_SU  = 6;
  localparam int CB_BI  = 5;
  localparam int CB_OI  = 4;
  localparam int CB_CE  = 3;
  localparam int CB_CO  = 2;
  localparam int CB_J   = 1;
  localparam int CB_FI  = 0;

  // Longest instruction (ADD/SUB); the step counter must reach MAX_LEN-1.
  localparam int unsigned MAX_LEN = 5;

  typedef enum logic [1:0] {
    StStopped = 2'd0,
    StActive  = 2'd1,
    StHalted  = 2'd2
  } seq_state_e;

  function automatic int unsigned instr_len(logic [3:0] op);
    int unsigned len;
    case (op)
      OP_LDA, OP_STA:                                 len = 4;
      OP_ADD, OP_SUB:                                 len = 5;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:   len = 3;
      default:                                        len = 2;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ucode_decode.sv
// Combinational microcode ROM: (step, opcode, flags) -> raw control word and last-step flag.
module ucode_decode
  import ucode_pkg::*;
#(
  parameter int unsigned O  = 4,
  parameter int unsigned T  = 3,
  parameter int unsigned CW = 16
) (
  input  logic [T-1:0]  t,
  input  logic [O-1:0]  ir,
  input  logic          cf,
  input  logic          zf,
  output logic [CW-1:0] ctrl_raw,
  output logic          last_step
);

  logic [3:0] op;

  assign op        = 4'(ir);
  assign last_step = (32'(t) == instr_len(op) - 32'd1);

  always_comb begin
    ctrl_raw = '0;
    case (32'(t))
      0: begin
        ctrl_raw[CB_CO] = 1'b1;
        ctrl_raw[CB_MI] = 1'b1;
      end
      1: begin
        ctrl_raw[CB_RO] = 1'b1;
        ctrl_raw[CB_II] = 1'b1;
        ctrl_raw[CB_CE] = 1'b1;
      end
      2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl_raw[CB_IO] = 1'b1;
            ctrl_raw[CB_MI] = 1'b1;
          end
          OP_LDI: begin
            ctrl_raw[CB_IO] = 1'b1;
            ctrl_raw[CB_AI] = 1'b1;
          end
          OP_JMP: begin
            ctrl_raw[CB_IO] = 1'b1;
            ctrl_raw[CB_J]  = 1'b1;
          end
          // Conditional jumps see the flags registered by the previous ALU op.
          OP_JC: begin
            ctrl_raw[CB_IO] = 1'b1;
            ctrl_raw[CB_J]  = cf;
          end
          OP_JZ: begin
            ctrl_raw[CB_IO] = 1'b1;
            ctrl_raw[CB_J]  = zf;
          end
          OP_OUT: begin
            ctrl_raw[CB_AO] = 1'b1;
            ctrl_raw[CB_OI] = 1'b1;
          end
          OP_HLT: ctrl_raw[CB_HLT] = 1'b1;
          default: ;
        endcase
      end
      3: begin
        case (op)
          OP_LDA: begin
            ctrl_raw[CB_RO] = 1'b1;
            ctrl_raw[CB_AI] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_raw[CB_RO] = 1'b1;
            ctrl_raw[CB_BI] = 1'b1;
          end
          OP_STA: begin
            ctrl_raw[CB_AO] = 1'b1;
            ctrl_raw[CB_RI] = 1'b1;
          end
          default: ;
        endcase
      end
      4: begin
        if (op == OP_ADD || op == OP_SUB) begin
          ctrl_raw[CB_EO] = 1'b1;
          ctrl_raw[CB_AI] = 1'b1;
          ctrl_raw[CB_FI] = 1'b1;
          ctrl_raw[CB_SU] = (op == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// Variable-length fetch/execute sequencer with run, single-step and halt modes.
module microsequencer
  import ucode_pkg::*;
#(
  parameter int unsigned O        = 4,
  parameter int unsigned MAXPHASE = 7,
  parameter int unsigned T        = $clog2(MAXPHASE + 1),
  parameter int unsigned CW       = 16,
  parameter int unsigned ICW      = 16
) (
  input  logic           clk,
  input  logic           clr_,
  input  logic           run,
  input  logic           step,
  input  logic [O-1:0]   ir,
  input  logic           cf,
  input  logic           zf,
  output logic [CW-1:0]  ctrl,
  output logic [T-1:0]   t,
  output logic           busy,
  output logic           halted,
  output logic           instr_done,
  output logic [ICW-1:0] icount
);

  if (MAXPHASE < 4 || MAX_LEN > MAXPHASE + 1 || CW < 16) begin : g_param_check
    $error("microsequencer: MAXPHASE must be >= 4 and CW >= 16");
  end

  seq_state_e     state_q, state_d;
  logic [T-1:0]   t_q, t_d;
  logic           step_q;
  logic [ICW-1:0] icount_q;
  logic [CW-1:0]  ctrl_raw;
  logic           last_step;
  logic           step_edge;
  logic           active;

  ucode_decode #(
    .O  (O),
    .T  (T),
    .CW (CW)
  ) u_decode (
    .t         (t_q),
    .ir        (ir),
    .cf        (cf),
    .zf        (zf),
    .ctrl_raw  (ctrl_raw),
    .last_step (last_step)
  );

  assign active    = (state_q == StActive);
  assign step_edge = step & ~step_q;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      StStopped: begin
        t_d = '0;
        // run takes priority; a coincident step edge is simply consumed.
        if (run || step_edge) state_d = StActive;
      end
      StActive: begin
        if (last_step) begin
          t_d = '0;
          if (ctrl_raw[CB_HLT]) state_d = StHalted;
          else if (!run)        state_d = StStopped;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      StHalted: t_d = '0;
      default: begin
        state_d = StStopped;
        t_d     = '0;
      end
    endcase
  end

  // step_q tracks step in every state so edges seen while busy/halted are dropped.
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      state_q  <= StStopped;
      t_q      <= '0;
      step_q   <= 1'b0;
      icount_q <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      step_q  <= step;
      if (active && last_step) icount_q <= icount_q + 1'b1;
    end
  end

  assign ctrl       = active ? ctrl_raw : '0;
  assign t          = t_q;
  assign busy       = active;
  assign halted     = (state_q == StHalted);
  assign instr_done = active & last_step;
  assign icount     = icount_q;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench: per-cycle vector table with scoreboard plus multi-cycle corner sequences.
module tb_microsequencer;

  logic        clk;
  logic        clr_;
  logic        run, step, cf, zf;
  logic [3:0]  ir;
  logic [15:0] ctrl;
  logic [2:0]  t;
  logic        busy, halted, instr_done;
  logic [15:0] icount;

  logic        run4;
  logic [3:0]  ir4;
  logic [15:0] ctrl4;
  logic [2:0]  t4;
  logic        busy4, halted4, done4;
  logic [3:0]  icount4;

  int checks = 0;
  int passes = 0;

  microsequencer u_dut (
    .clk        (clk),
    .clr_       (clr_),
    .run        (run),
    .step       (step),
    .ir         (ir),
    .cf         (cf),
    .zf         (zf),
    .ctrl       (ctrl),
    .t          (t),
    .busy       (busy),
    .halted     (halted),
    .instr_done (instr_done),
    .icount     (icount)
  );

  microsequencer #(.ICW(4)) u_dut4 (
    .clk        (clk),
    .clr_       (clr_),
    .run        (run4),
    .step       (1'b0),
    .ir         (ir4),
    .cf         (1'b0),
    .zf         (1'b0),
    .ctrl       (ctrl4),
    .t          (t4),
    .busy       (busy4),
    .halted     (halted4),
    .instr_done (done4),
    .icount     (icount4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        step;
    logic [3:0]  ir;
    logic        cf;
    logic        zf;
    logic [15:0] ctrl;
    logic [2:0]  t;
    logic        busy;
    logic        halted;
    logic        done;
    logic [15:0] icount;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void add(logic r, logic s, logic [3:0] i, logic c, logic z,
                              logic [15:0] ec, logic [2:0] et, logic eb, logic eh,
                              logic ed, logic [15:0] ei);
    vec_t v;
    v.run = r; v.step = s; v.ir = i; v.cf = c; v.zf = z;
    v.ctrl = ec; v.t = et; v.busy = eb; v.halted = eh; v.done = ed; v.icount = ei;
    vecs.push_back(v);
  endfunction

  // Called just after a rising edge; compares on the falling edge.
  task automatic apply(input vec_t v);
    vec_t e;
    run = v.run; step = v.step; ir = v.ir; cf = v.cf; zf = v.zf;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("ctrl", 32'(ctrl), 32'(e.ctrl));
    chk("t", 32'(t), 32'(e.t));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("halted", 32'(halted), 32'(e.halted));
    chk("instr_done", 32'(instr_done), 32'(e.done));
    chk("icount", 32'(icount), 32'(e.icount));
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int k = lo; k < hi; k++) apply(vecs[k]);
  endtask

  task automatic do_reset();
    run = 0; step = 0; cf = 0; zf = 0; ir = 0; run4 = 0; ir4 = 0;
    clr_ = 0;
    #1;
    chk("rst ctrl", 32'(ctrl), 0);
    chk("rst t", 32'(t), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst halted", 32'(halted), 0);
    chk("rst done", 32'(instr_done), 0);
    chk("rst icount", 32'(icount), 0);
    chk("rst icount4", 32'(icount4), 0);
    @(posedge clk);
    #1;
    clr_ = 1;
  endtask

  int seg1;
  int n;
  bit found;

  initial begin
    clr_ = 0; run = 0; step = 0; cf = 0; zf = 0; ir = 0; run4 = 0; ir4 = 0;

    // Program LDI, ADD, OUT, HLT under run.
    add(1, 0, 5, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 5, 0, 0, 16'h4004, 0, 1, 0, 0, 0);
    add(1, 0, 5, 0, 0, 16'h1408, 1, 1, 0, 0, 0);
    add(1, 0, 5, 0, 0, 16'h0A00, 2, 1, 0, 1, 0);
    add(1, 0, 2, 0, 0, 16'h4004, 0, 1, 0, 0, 1);
    add(1, 0, 2, 0, 0, 16'h1408, 1, 1, 0, 0, 1);
    add(1, 0, 2, 0, 0, 16'h4800, 2, 1, 0, 0, 1);
    add(1, 0, 2, 0, 0, 16'h1020, 3, 1, 0, 0, 1);
    add(1, 0, 2, 0, 0, 16'h0281, 4, 1, 0, 1, 1);
    add(1, 0, 14, 0, 0, 16'h4004, 0, 1, 0, 0, 2);
    add(1, 0, 14, 0, 0, 16'h1408, 1, 1, 0, 0, 2);
    add(1, 0, 14, 0, 0, 16'h0110, 2, 1, 0, 1, 2);
    add(1, 0, 15, 0, 0, 16'h4004, 0, 1, 0, 0, 3);
    add(1, 0, 15, 0, 0, 16'h1408, 1, 1, 0, 0, 3);
    add(1, 0, 15, 0, 0, 16'h8000, 2, 1, 0, 1, 3);
    add(1, 0, 15, 0, 0, 16'h0000, 0, 0, 1, 0, 4);
    add(0, 0, 15, 0, 0, 16'h0000, 0, 0, 1, 0, 4);
    add(0, 1, 15, 0, 0, 16'h0000, 0, 0, 1, 0, 4);
    add(0, 0, 15, 0, 0, 16'h0000, 0, 0, 1, 0, 4);
    seg1 = vecs.size();

    // Single step of LDA.
    add(0, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 16'h4004, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 16'h1408, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 16'h4800, 2, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 16'h1200, 3, 1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    // JC with cf=0, then cf=1; run drops on the final step.
    add(1, 0, 7, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    add(1, 0, 7, 0, 0, 16'h4004, 0, 1, 0, 0, 1);
    add(1, 0, 7, 0, 0, 16'h1408, 1, 1, 0, 0, 1);
    add(1, 0, 7, 0, 0, 16'h0800, 2, 1, 0, 1, 1);
    add(1, 0, 7, 1, 0, 16'h4004, 0, 1, 0, 0, 2);
    add(1, 0, 7, 1, 0, 16'h1408, 1, 1, 0, 0, 2);
    add(0, 0, 7, 1, 0, 16'h0802, 2, 1, 0, 1, 2);
    add(0, 0, 7, 1, 0, 16'h0000, 0, 0, 0, 0, 3);
    // SUB with run dropped at t1: completes, then stops.
    add(1, 0, 3, 0, 0, 16'h0000, 0, 0, 0, 0, 3);
    add(1, 0, 3, 0, 0, 16'h4004, 0, 1, 0, 0, 3);
    add(0, 0, 3, 0, 0, 16'h1408, 1, 1, 0, 0, 3);
    add(0, 0, 3, 0, 0, 16'h4800, 2, 1, 0, 0, 3);
    add(0, 0, 3, 0, 0, 16'h1020, 3, 1, 0, 0, 3);
    add(0, 0, 3, 0, 0, 16'h02C1, 4, 1, 0, 1, 3);
    add(0, 0, 3, 0, 0, 16'h0000, 0, 0, 0, 0, 4);
    add(0, 0, 3, 0, 0, 16'h0000, 0, 0, 0, 0, 4);
    // Step held high, with a second edge mid-instruction: one LDI only.
    add(0, 1, 5, 0, 0, 16'h0000, 0, 0, 0, 0, 4);
    add(0, 1, 5, 0, 0, 16'h4004, 0, 1, 0, 0, 4);
    add(0, 0, 5, 0, 0, 16'h1408, 1, 1, 0, 0, 4);
    add(0, 1, 5, 0, 0, 16'h0A00, 2, 1, 0, 1, 4);
    for (int k = 0; k < 18; k++) add(0, 1, 5, 0, 0, 16'h0000, 0, 0, 0, 0, 5);
    add(0, 0, 5, 0, 0, 16'h0000, 0, 0, 0, 0, 5);

    @(posedge clk);
    #1;
    do_reset();

    // Asynchronous reset in the middle of the second ADD at t=3.
    run = 1; ir = 4'd2;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk);
      #1;
      if (busy && icount == 16'd1 && t == 3'd3) found = 1;
    end
    chk("mid-add reached", 32'(found), 1);
    run = 0;
    #1 clr_ = 0;
    #1 clr_ = 1;
    #1;
    chk("async t", 32'(t), 0);
    chk("async ctrl", 32'(ctrl), 0);
    chk("async busy", 32'(busy), 0);
    chk("async icount", 32'(icount), 0);
    @(posedge clk);
    #1;
    chk("async stays stopped", 32'(busy), 0);

    do_reset();
    run_rows(0, seg1);
    do_reset();
    run_rows(seg1, vecs.size());
    chk("scoreboard drained", 32'(exp_q.size()), 0);

    // 4-bit counter wraps after 16 NOPs.
    do_reset();
    run4 = 1;
    n = 0;
    for (int c = 0; c < 60 && n < 16; c++) begin
      @(negedge clk);
      if (done4) begin
        n++;
        @(posedge clk);
        #1;
        if (n == 15) chk("icount4 at 15", 32'(icount4), 15);
        if (n == 16) chk("icount4 wrap", 32'(icount4), 0);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk("nop retire count", 32'(n), 16);
    run4 = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
